// File: rtl/mem_arb4_pkg.sv
// Shared definitions for the four-master memory arbiter.
package mem_arb4_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } arb_state_e;

  // Default number of BUSY cycles tolerated without mem_ready.
  localparam int unsigned TimeoutDefault = 255;

  // One-hot decode of a master index.
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] one;
    one = 4'b0001;
    return one << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first requester at or after ptr, counting upward mod 4.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       any,
  output logic [1:0] idx
);

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    any = |req;
    idx = ptr;
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr + 2'(i)]) begin
        idx = ptr + 2'(i);
      end
    end
  end

endmodule

// File: rtl/mem_arb4.sv
// Four-master round-robin arbiter in front of a single shared memory port.
// One access at a time: IDLE picks a master, BUSY waits for mem_ready (or a
// timeout), RESP returns a one-cycle done pulse to the granted master.
module mem_arb4
  import mem_arb4_pkg::*;
#(
  parameter int unsigned Width   = 32,
  parameter int unsigned Timeout = TimeoutDefault
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [Width-1:0] addr0,
  input  logic [Width-1:0] addr1,
  input  logic [Width-1:0] addr2,
  input  logic [Width-1:0] addr3,
  input  logic [Width-1:0] wdata0,
  input  logic [Width-1:0] wdata1,
  input  logic [Width-1:0] wdata2,
  input  logic [Width-1:0] wdata3,
  input  logic [3:0]       we,
  input  logic             mem_ready,
  input  logic [Width-1:0] mem_rdata,
  output logic             mem_valid,
  output logic [Width-1:0] mem_addr,
  output logic [Width-1:0] mem_wdata,
  output logic             mem_we,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic [3:0]       done,
  output logic [Width-1:0] rdata,
  output logic             err
);

  // Wide enough to hold the value Timeout itself.
  localparam int unsigned CntW = (Timeout < 1) ? 1 : $clog2(Timeout + 1);

  arb_state_e      state;
  logic [1:0]      ptr;
  logic [CntW-1:0] cnt;
  logic [CntW-1:0] cnt_inc;
  logic            pick_any;
  logic [1:0]      pick_idx;

  assign cnt_inc = cnt + CntW'(1);

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Arbiter FSM; every output it drives is registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      ptr       <= 2'd0;
      sel       <= 2'd0;
      gnt       <= 4'b0000;
      mem_valid <= 1'b0;
      done      <= 4'b0000;
      err       <= 1'b0;
      rdata     <= '0;
      cnt       <= '0;
    end else begin
      done <= 4'b0000;
      err  <= 1'b0;
      unique case (state)
        StIdle: begin
          if (pick_any) begin
            sel       <= pick_idx;
            gnt       <= onehot4(pick_idx);
            cnt       <= '0;
            mem_valid <= 1'b1;
            state     <= StBusy;
          end
        end
        StBusy: begin
          // Ready wins over a timeout that would expire in the same cycle.
          if (mem_ready) begin
            rdata     <= mem_rdata;
            ptr       <= sel + 2'd1;
            done      <= onehot4(sel);
            gnt       <= 4'b0000;
            mem_valid <= 1'b0;
            state     <= StResp;
          end else if (cnt_inc == CntW'(Timeout)) begin
            err       <= 1'b1;
            ptr       <= sel + 2'd1;
            done      <= onehot4(sel);
            gnt       <= 4'b0000;
            mem_valid <= 1'b0;
            state     <= StResp;
          end else begin
            cnt <= cnt_inc;
          end
        end
        StResp: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  // Shared-port mux on the registered select; quiet outside BUSY.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_valid) begin
      unique case (sel)
        2'd0: begin
          mem_addr  = addr0;
          mem_wdata = wdata0;
        end
        2'd1: begin
          mem_addr  = addr1;
          mem_wdata = wdata1;
        end
        2'd2: begin
          mem_addr  = addr2;
          mem_wdata = wdata2;
        end
        default: begin
          mem_addr  = addr3;
          mem_wdata = wdata3;
        end
      endcase
    end
  end

  assign mem_we = we[sel] & mem_valid;

  // Grant and done are never multi-hot.
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));
  a_done_onehot0 : assert property (@(posedge clk) disable iff (reset) $onehot0(done));

endmodule

// File: doc/mem_arb4.md
MEM_ARB4 -- requirements
Module: mem_arb4

Interface
REQ-001 Parameter Width, default 32, width of the address, write-data and read-data buses.
REQ-002 Parameter Timeout, default 255, maximum number of BUSY cycles allowed without mem_ready.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  4  per-master request; held high by master j until done[j] is seen.
REQ-006 addr0..addr3  input  Width each  per-master address.
REQ-007 wdata0..wdata3  input  Width each  per-master write data.
REQ-008 we  input  4  per-master write enable.
REQ-009 mem_ready  input  1  shared memory has completed the current access.
REQ-010 mem_rdata  input  Width  shared memory read data, valid when mem_ready=1.
REQ-011 mem_valid  output  1  access in progress on the shared port.
REQ-012 mem_addr, mem_wdata  output  Width each  muxed address and write data of the granted master.
REQ-013 mem_we  output  1  muxed write enable of the granted master, gated by mem_valid.
REQ-014 gnt  output  4  one-hot grant; all zero when idle.
REQ-015 sel  output  2  index of the granted master; usable as a 4:1 mux select.
REQ-016 done  output  4  one-cycle completion pulse to the granted master.
REQ-017 rdata  output  Width  registered copy of mem_rdata, valid in the cycle done is high.
REQ-018 err  output  1  one-cycle pulse on timeout.

Function
REQ-019 FSM has three states: IDLE, BUSY, RESP.
REQ-020 IDLE: if req!=0, pick the first requester at or after the 2-bit pointer ptr, counting upward mod 4; register sel and gnt, clear the timeout counter, go to BUSY; else stay in IDLE.
REQ-021 BUSY: mem_valid=1; mem_addr, mem_wdata and mem_we are taken from master sel (combinational mux on the registered sel).
REQ-022 BUSY with mem_ready=1: capture mem_rdata into rdata, set ptr<=sel+1 mod 4, go to RESP.
REQ-023 BUSY with mem_ready=0: increment the counter; when the counter equals Timeout, pulse err, set ptr<=sel+1, go to RESP without updating rdata.
REQ-024 RESP: done[sel]=1 for exactly one cycle, mem_valid=0, gnt cleared; go to IDLE.
REQ-025 Arbitration latency: a request seen in IDLE at cycle N gives mem_valid at cycle N+1. The minimum transaction length is 3 cycles (IDLE, BUSY, RESP).
REQ-026 A master dropping req during BUSY does not abort; the access completes and done is still pulsed.
REQ-027 Requests in RESP are ignored until the following IDLE cycle.
REQ-028 ptr wraps 3->0. With all four requesting continuously, grants follow the order 0,1,2,3,0...
REQ-029 mem_ready in IDLE or RESP is ignored.
REQ-030 mem_ready=1 in the same cycle the counter reaches Timeout: the ready takes precedence; no err, and rdata is captured.
REQ-031 gnt, sel and mem_addr remain stable throughout BUSY.

Reset
REQ-032 While reset=1: state=IDLE, ptr=0, sel=0, gnt=0, mem_valid=0, done=0, err=0, rdata=0, counter=0.
REQ-033 Reset asserted mid-BUSY abandons the access with no done and no err; the first post-reset grant starts from master 0.

Structure
REQ-034 FSM state encodings and the Timeout default belong in the shared package/include used by the processor modules.
REQ-035 One sub-module, rr_pick4: combinational round-robin picker (req[3:0], ptr[1:0] -> any, idx[1:0]).
REQ-036 Counter width is derived from Timeout; no other submodules.

Verification
REQ-037 Single request: req=4'b0100, addr2=32'h100, mem_ready one cycle after mem_valid -> sel=2, mem_addr=32'h100, done=4'b0100 in RESP, rdata=mem_rdata.
REQ-038 All requesting, mem_ready always 1 -> grant order 0,1,2,3,0; one done every 3 cycles.
REQ-039 Timeout: Timeout=4, mem_ready held at 0 -> err pulses after 4 BUSY cycles, then done pulses to the granted master, then IDLE.
REQ-040 Write: req=4'b0001, we=4'b0001, wdata0=32'hDEADBEEF -> mem_we=1 and mem_wdata=32'hDEADBEEF throughout BUSY.
REQ-041 Reset mid-BUSY on master 3 -> all outputs 0 the next cycle; then req=4'b1001 -> master 0 is granted first.
REQ-042 mem_ready in the same cycle as the timeout edge -> no err, rdata captured, done pulsed.
